// File: rtl/add64_pkg.sv
// Shared constants, FSM state type and slice-carry helper for the 64-bit adders.
package add64_pkg;
  localparam int SLICE_W = 16;
  localparam int NSLICE  = 4;
  localparam int DATA_W  = SLICE_W * NSLICE;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic logic slice_cout(input logic gx, input logic px, input logic cin);
    return gx | (px & cin);
  endfunction
endpackage

// File: rtl/add64_seq_cla16.sv
// 16-bit carry-lookahead slice: four 4-bit groups with group generate/propagate.
module CLA_16
  import add64_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        gx_o,
  output logic        px_o
);
  logic [15:0] p, g;
  logic [3:0]  gg, pg;
  logic [4:0]  gc;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    gg = '0;
    pg = '1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
        pg[k] = pg[k] & p[4*k+j];
      end
    end
  end

  // Group carries from the lookahead terms; bit carries only ripple inside a group.
  always_comb begin
    logic c;
    gc[0] = cin_i;
    for (int k = 0; k < 4; k++) gc[k+1] = slice_cout(gg[k], pg[k], gc[k]);
    sum_o = '0;
    for (int k = 0; k < 4; k++) begin
      c = gc[k];
      for (int j = 0; j < 4; j++) begin
        sum_o[4*k+j] = p[4*k+j] ^ c;
        c = slice_cout(g[4*k+j], p[4*k+j], c);
      end
    end
  end

  always_comb begin
    gx_o = 1'b0;
    for (int k = 0; k < 4; k++) gx_o = gg[k] | (pg[k] & gx_o);
  end
  assign px_o = &pg;
endmodule

// File: rtl/add64_seq.sv
// Multi-cycle 64-bit add/sub: one CLA_16 slice reused over four RUN cycles.
module add64_seq
  import add64_pkg::*;
#(
  parameter int SLICE_W = add64_pkg::SLICE_W,
  parameter int NSLICE  = add64_pkg::NSLICE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NSLICE-1:0] in_a,
  input  logic [SLICE_W*NSLICE-1:0] in_b,
  input  logic                      in_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE_W*NSLICE-1:0] out_sum,
  output logic                      out_cout,
  output logic                      out_ovf,
  output logic                      busy
);
  localparam int W  = SLICE_W * NSLICE;
  localparam int IW = $clog2(NSLICE);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            cout_q, cout_d, ovf_q, ovf_d;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_gx, sl_px, sl_cout;

  assign sl_a    = a_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_b    = b_q[idx_q*SLICE_W +: SLICE_W];
  assign sl_cout = slice_cout(sl_gx, sl_px, carry_q);

  CLA_16 u_cla (
    .a_i   (sl_a),
    .b_i   (sl_b),
    .cin_i (carry_q),
    .sum_o (sl_sum),
    .gx_o  (sl_gx),
    .px_o  (sl_px)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = in_a;
        b_d     = in_sub ? ~in_b : in_b;
        carry_d = in_sub;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NSLICE-1)) begin
          cout_d  = sl_cout;
          // sl_sum[MSB] is the bit 63 being written this cycle
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (sl_sum[SLICE_W-1] != a_q[W-1]);
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_add64_seq.sv
// Vector table, random ops vs arithmetic model, backpressure and mid-op reset.
module tb_add64_seq;
  logic        clk = 0;
  logic        rst;
  logic        in_valid, in_ready, in_sub;
  logic [63:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf, busy;
  logic [63:0] out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add64_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  typedef struct {
    logic [63:0] a, b;
    logic        sub;
    logic [63:0] sum;
    logic        cout, ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 65-bit arithmetic and signed comparison of operands/result.
  task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                       output logic [63:0] s, output logic c, output logic v);
    logic [64:0] r;
    longint sa, sb, ss;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + 65'd1;
    else     r = {1'b0, a} + {1'b0, b};
    s = r[63:0];
    c = r[64];
    sa = a; sb = b; ss = s;
    if (sub) v = ((sa < 0) != (sb < 0)) && ((ss < 0) != (sa < 0));
    else     v = ((sa < 0) == (sb < 0)) && ((ss < 0) != (sa < 0));
  endtask

  // Offer a request, wait for accept, check latency and results, hold in DONE, then drain.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic [63:0] es, input logic ec,
                       input logic eo, input int hold);
    int n;
    in_a = a; in_b = b; in_sub = sub; in_valid = 1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL %s accept_timeout: in_ready never rose", tag);
      in_valid = 0;
      return;
    end
    @(negedge clk);
    in_valid = 0;
    in_a = ~a; in_b = ~b; in_sub = ~sub;
    n = 1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, " latency"}, 64'(n), 64'd5);
    chk({tag, " sum"}, out_sum, es);
    chk({tag, " cout"}, 64'(out_cout), 64'(ec));
    chk({tag, " ovf"}, 64'(out_ovf), 64'(eo));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
      chk({tag, " hold sum"}, out_sum, es);
      chk({tag, " hold cout"}, 64'(out_cout), 64'(ec));
      chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, " valid drop"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    vec_t vt[5];
    logic [63:0] ra, rb, es, s2;
    logic rs, ec, eo, c2, o2;
    int n;

    vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
    vt[1] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vt[2] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vt[3] = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
    vt[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};

    rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_sub = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_sum", out_sum, 64'd0);
    chk("reset out_cout", 64'(out_cout), 64'd0);
    chk("reset out_ovf", 64'(out_ovf), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 5; i++)
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sub,
            vt[i].sum, vt[i].cout, vt[i].ovf, 0);

    // Backpressure with a second request waiting behind the held result.
    in_a = 64'h1234_5678_9ABC_DEF0; in_b = 64'h0FED_CBA9_8765_4321; in_sub = 0; in_valid = 1;
    @(negedge clk);
    in_a = 64'd100; in_b = 64'd58; in_sub = 1;
    n = 1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp latency", 64'(n), 64'd5);
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, es, ec, eo);
    for (int h = 0; h < 3; h++) begin
      chk("bp valid", 64'(out_valid), 64'd1);
      chk("bp sum", out_sum, es);
      chk("bp cout", 64'(out_cout), 64'(ec));
      chk("bp in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1;
    chk("bp in_ready at handshake", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 0;
    chk("bp second accept ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp2 latency", 64'(n), 64'd5);
    chk("bp2 sum", out_sum, 64'd42);
    chk("bp2 cout", 64'(out_cout), 64'd1);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;

    // Reset while idx==2 (third RUN cycle after accept).
    in_a = 64'hFFFF_0000_FFFF_0000; in_b = 64'h0001_FFFF_0001_FFFF; in_sub = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst mid out_valid", 64'(out_valid), 64'd0);
    chk("rst mid in_ready", 64'(in_ready), 64'd1);
    chk("rst mid out_sum", out_sum, 64'd0);
    chk("rst mid busy", 64'(busy), 64'd0);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("rst mid no result", 64'(n), 64'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) ra = 64'hFFFF_FFFF_FFFF_FFFF;
      if (i % 8 == 1) rb = ra;
      if (i % 8 == 2) ra[63:0] = {ra[63:48], 16'hFFFF, 32'hFFFF_FFFF};
      model(ra, rb, rs, s2, c2, o2);
      do_op($sformatf("rnd%0d", i), ra, rb, rs, s2, c2, o2, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end
endmodule
